sdram_stream_adapter: RTL

SDRAM_STREAM_ADAPTER -- requirements
Module: sdram_stream_adapter

---
 rtl/sdram_stream_adapter_pkg.sv | 22 ++
 rtl/sdram_stream_adapter_if.sv | 28 ++
 rtl/sdram_stream_adapter_fifo.sv | 50 +++++
 rtl/sdram_stream_adapter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sdram_stream_adapter_pkg.sv
// Shared types and geometry for the SDRAM stream adapter.
// No logic; constants only.
// Not applicable (no handshakes).
package sdram_stream_pkg;

   localparam int SD_ADDR_W = 13;
   localparam int SD_DATA_W = 16;
   localparam int SD_WORDS  = 8192;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_XFER = 2'd2,
      ST_CAPT = 2'd3
   } state_e;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_e;

endpackage

// File: rtl/sdram_stream_adapter_if.sv
// Producer write stream, read-burst request and consumer read stream.
// Pure wiring, zero latency.
// s_wready and m_rready carry the valid/ready backpressure.
interface sdram_stream_adapter_if;
   import sdram_stream_pkg::*;

   logic [SD_DATA_W-1:0] s_wdata;
   logic                 s_wvalid;
   logic                 s_wready;
   logic                 rd_req;
   logic [7:0]           rd_len;
   logic                 rd_busy;
   logic [SD_DATA_W-1:0] m_rdata;
   logic                 m_rvalid;
   logic                 m_rready;

   // Adapter side
   modport slave (
      input  s_wdata, s_wvalid, rd_req, rd_len, m_rready,
      output s_wready, rd_busy, m_rdata, m_rvalid
   );

   // Producer / consumer side
   modport master (
      output s_wdata, s_wvalid, rd_req, rd_len, m_rready,
      input  s_wready, rd_busy, m_rdata, m_rvalid
   );
endinterface

// File: rtl/sdram_stream_adapter_fifo.sv
// Synchronous FIFO with occupancy count; head word is always visible.
// Write-to-read latency one cycle.
// Push ignored when full, pop ignored when empty; callers gate on count.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop  && (count != '0);
   assign pop_dat = mem[rd_ptr];

   // Storage is not reset; outputs that matter are gated by count upstream.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sdram_stream_adapter.sv
// Bridges a write stream and read bursts onto a single-word SDRAM controller port.
// 3 cycles/word back-to-back (SEL,XFER,CAPT), 4 from IDLE; reads return via FIFO.
// s_wready low when write FIFO full; RD grants stall while read FIFO lacks space.
module sdram_stream_adapter
   import sdram_stream_pkg::*;
#(
   parameter int WFIFO_DEPTH = 4,
   parameter int RFIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   sdram_stream_adapter_if.slave bus,
   output logic                  sd_chip_sel,
   output logic                  sd_wr_en,
   output logic                  sd_rd_en,
   output logic [SD_DATA_W-1:0]  sd_data_in,
   input  logic [SD_DATA_W-1:0]  sd_data_out,
   output logic [SD_ADDR_W-1:0]  mem_ptr
);
   localparam int WCW = $clog2(WFIFO_DEPTH) + 1;
   localparam int RCW = $clog2(RFIFO_DEPTH) + 1;

   state_e               state;
   state_e               state_nxt;
   op_e                  op;
   op_e                  op_nxt;
   logic                 rdy_en;
   logic [7:0]           rd_remaining;
   logic [7:0]           rd_left;

   logic [WCW-1:0]       wbuf_count;
   logic [SD_DATA_W-1:0] wbuf_head;
   logic [RCW-1:0]       rbuf_count;
   logic [SD_DATA_W-1:0] rbuf_head;
   logic [RCW:0]         rbuf_level;

   logic wr_push, wr_pop, capt_push, rd_pop, rd_accept;
   logic wbuf_empty, wbuf_full, decide, grant_wr, grant_rd;

   assign wbuf_empty = (wbuf_count == '0);
   assign wbuf_full  = (wbuf_count == WCW'(WFIFO_DEPTH));

   assign wr_push   = bus.s_wvalid && bus.s_wready;
   assign wr_pop    = (state == ST_XFER) && (op == OP_WR);
   assign capt_push = (state == ST_CAPT) && (op == OP_RD);
   assign rd_pop    = bus.m_rvalid && bus.m_rready;
   assign rd_accept = bus.rd_req && !bus.rd_busy && (bus.rd_len != 8'd0);

   // Arbitrate on post-capture state so the word landing this cycle is counted.
   assign rd_left    = rd_remaining - {7'd0, capt_push};
   assign rbuf_level = {1'b0, rbuf_count} + {{RCW{1'b0}}, capt_push};
   assign decide     = (state == ST_IDLE) || (state == ST_CAPT);
   assign grant_wr   = !wbuf_empty;
   assign grant_rd   = (rd_left != 8'd0) && (rbuf_level < (RCW+1)'(RFIFO_DEPTH));

   sync_fifo #(.WIDTH(SD_DATA_W), .DEPTH(WFIFO_DEPTH)) u_wbuf (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (wr_push),
      .push_dat (bus.s_wdata),
      .pop      (wr_pop),
      .pop_dat  (wbuf_head),
      .count    (wbuf_count)
   );

   sync_fifo #(.WIDTH(SD_DATA_W), .DEPTH(RFIFO_DEPTH)) u_rbuf (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (capt_push),
      .push_dat (sd_data_out),
      .pop      (rd_pop),
      .pop_dat  (rbuf_head),
      .count    (rbuf_count)
   );

   // Next state: writes win the slot, then reads with guaranteed buffer room.
   always_comb begin
      state_nxt = state;
      op_nxt    = op;
      case (state)
         ST_SEL:  state_nxt = ST_XFER;
         ST_XFER: state_nxt = ST_CAPT;
         default: begin
            if (decide && grant_wr) begin
               state_nxt = ST_SEL;
               op_nxt    = OP_WR;
            end else if (decide && grant_rd) begin
               state_nxt = ST_SEL;
               op_nxt    = OP_RD;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // State and op registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         op    <= OP_WR;
      end else begin
         state <= state_nxt;
         op    <= op_nxt;
      end
   end

   // Outstanding read words: loaded on accept, counted down at each capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       rd_remaining <= 8'd0;
      else if (rd_accept) rd_remaining <= bus.rd_len;
      else if (capt_push) rd_remaining <= rd_left;
   end

   // Shadow of the controller address counter, which advances once per XFER.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_ptr <= '0;
      end else if (state == ST_XFER) begin
         if (mem_ptr == SD_ADDR_W'(SD_WORDS - 1)) mem_ptr <= '0;
         else                                     mem_ptr <= mem_ptr + 1'b1;
      end
   end

   // Holds s_wready low until the first clock after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdy_en <= 1'b0;
      else          rdy_en <= 1'b1;
   end

   assign bus.s_wready = rdy_en && !wbuf_full;
   assign bus.rd_busy  = (rd_remaining != 8'd0);
   assign bus.m_rvalid = (rbuf_count != '0);
   assign bus.m_rdata  = bus.m_rvalid ? rbuf_head : '0;

   assign sd_chip_sel = (state == ST_SEL);
   assign sd_wr_en    = (state == ST_XFER) && (op == OP_WR);
   assign sd_rd_en    = (state == ST_XFER) && (op == OP_RD);
   assign sd_data_in  = sd_wr_en ? wbuf_head : '0;
endmodule
